// File: rtl/tb_uart_pkg.sv
// Shared types and constants for the tb_uart serial peer.
// Contents: DATA_BITS, the TX/RX state enums.
// The optional receive path is enabled by the macro TB_UART_RX_EN (see tb_uart.sv).
package tb_uart_pkg;

  localparam int DATA_BITS = 8;

  // Enumerator names carry a TX_/RX_ prefix so both enums can share one package scope.
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEAR
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/tb_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer on ser_rx plus the RX FSM.
// Ports:
//   clock, reset (async, active-high)
//   ser_rx        serial input (asynchronous to clock)
//   rx_data       last received byte (updated on good and bad stop bits)
//   rx_valid      one-cycle pulse, good byte
//   rx_frame_err  one-cycle pulse, stop bit sampled low
module tb_uart_rx
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  // Synchronizer and edge-detect history reset high so the idle line is not seen as a start.
  logic sync1_q, sync2_q, prev_q;

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the line at the middle of the start bit to reject glitches.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) state_d = RX_STOP;
          else                   bit_d   = bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          data_d  = shift_q;
          state_d = RX_WAIT_IDLE;
          if (sync2_q) valid_d = 1'b1;
          else         ferr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_WAIT_IDLE: begin
        // A held-low line (break) must return high before another frame can start.
        if (sync2_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= ser_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/tb_uart.sv
// Bench-side 8N1 UART peer: transmits bytes on ser_tx on request and,
// when TB_UART_RX_EN is defined, decodes bytes arriving on ser_rx.
// Ports:
//   clock, reset (async, active-high)
//   ser_rx / ser_tx            serial lines (ser_tx idles high)
//   tx_start, tx_data          send request (level) and byte, latched at frame start
//   tx_busy, tx_clear_req      frame in flight / frame done awaiting tx_start low
//   rx_data, rx_valid, rx_frame_err   receive results (constant 0 without TB_UART_RX_EN)
// Send handshake: the requester raises tx_start with tx_data stable; the frame
// starts on the next edge seen in idle. When the frame ends, tx_clear_req stays
// high until tx_start is seen low, so one request level sends exactly one frame.
module tb_uart
  import tb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ser_rx,
  output logic                 ser_tx,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_clear_req,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  tx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ser_tx_q, ser_tx_d;
  logic                 busy_q, busy_d;
  logic                 clr_q, clr_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    ser_tx_d = ser_tx_q;
    busy_d   = busy_q;
    clr_d    = clr_q;
    case (state_q)
      TX_IDLE: begin
        if (tx_start) begin
          state_d  = TX_START;
          shift_d  = tx_data;
          cnt_d    = '0;
          ser_tx_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      TX_START: begin
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = TX_DATA;
          ser_tx_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d  = TX_STOP;
            ser_tx_d = 1'b1;
          end else begin
            bit_d    = bit_q + BW'(1);
            ser_tx_d = shift_q[0];
            shift_d  = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = TX_CLEAR;
          busy_d  = 1'b0;
          // Only flag the clear request if the requester is still holding tx_start.
          clr_d   = tx_start;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_CLEAR: begin
        if (!tx_start) begin
          state_d = TX_IDLE;
          clr_d   = 1'b0;
        end else begin
          clr_d = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      ser_tx_q <= 1'b1;
      busy_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      ser_tx_q <= ser_tx_d;
      busy_q   <= busy_d;
      clr_q    <= clr_d;
    end
  end

  assign ser_tx       = ser_tx_q;
  assign tx_busy      = busy_q;
  assign tx_clear_req = clr_q;

`ifdef TB_UART_RX_EN
  tb_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock       (clock),
    .reset       (reset),
    .ser_rx      (ser_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );
`else
  logic unused_ser_rx;
  assign unused_ser_rx = ser_rx;
  assign rx_data       = '0;
  assign rx_valid      = 1'b0;
  assign rx_frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tb_uart.sv
// Self-checking bench for tb_uart with CLKS_PER_BIT=16. Adapts its expectations
// to whether TB_UART_RX_EN is defined for the build.
module tb_tb_uart;

  localparam int CPB = 16;
`ifdef TB_UART_RX_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  logic loopback = 1'b0;
  logic rx_line  = 1'b1;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];

  assign ser_rx = loopback ? ser_tx : rx_line;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock       (clock),
    .reset       (reset),
    .ser_rx      (ser_rx),
    .ser_tx      (ser_tx),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_clear_req(tx_clear_req),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected got=%h exp=none", rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data got=%h exp=%h", rx_data, e);
          end
        end
      end
      if (rx_frame_err) ferr_cnt++;
    end
  end

  // ---------------- reference: serial frame of a byte ----------------
  function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_rx_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = frame_of(d, stop);
    for (int b = 0; b < 10; b++) begin
      @(negedge clock);
      rx_line = f[b];
      repeat (CPB - 1) @(negedge clock);
    end
  endtask

  // Full TX frame with waveform check. hold>=0: keep tx_start high that many
  // cycles after the frame; hold<0: release tx_start right after it is taken.
  task automatic run_tx(input logic [7:0] d, input int hold);
    logic [9:0] f;
    f = frame_of(d, 1'b1);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clock);
      if (i == 0 && hold < 0) tx_start = 1'b0;
      if (i == 20) tx_data = ~d;
      if (hold >= 0 && i == 40) tx_start = 1'b0;
      if (hold >= 0 && i == 45) tx_start = 1'b1;
      checks++;
      if (ser_tx !== f[i / CPB] || tx_busy !== 1'b1 || tx_clear_req !== 1'b0) begin
        errors++;
        $display("FAIL tx_frame i=%0d got ser_tx=%b busy=%b clr=%b exp ser_tx=%b busy=1 clr=0",
                 i, ser_tx, tx_busy, tx_clear_req, f[i / CPB]);
      end
    end
    @(negedge clock);
    checks++;
    if (tx_busy !== 1'b0 || ser_tx !== 1'b1 || tx_clear_req !== (hold >= 0)) begin
      errors++;
      $display("FAIL tx_end got busy=%b ser_tx=%b clr=%b exp busy=0 ser_tx=1 clr=%b",
               tx_busy, ser_tx, tx_clear_req, hold >= 0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      checks++;
      if (tx_busy !== 1'b0 || ser_tx !== 1'b1 || tx_clear_req !== 1'b1) begin
        errors++;
        $display("FAIL tx_hold i=%0d got busy=%b ser_tx=%b clr=%b exp 0 1 1",
                 i, tx_busy, ser_tx, tx_clear_req);
      end
    end
    tx_start = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (tx_clear_req !== 1'b0 || tx_busy !== 1'b0 || ser_tx !== 1'b1) begin
        errors++;
        $display("FAIL tx_release got clr=%b busy=%b ser_tx=%b exp 0 0 1",
                 tx_clear_req, tx_busy, ser_tx);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b0 ||
        rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got tx=%b busy=%b clr=%b data=%h v=%b fe=%b",
               ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_tx_held;
    run_tx(8'hA5, 100);
    run_tx(8'($urandom_range(0, 255)), 7);
  endtask

  task automatic test_tx_pulse;
    run_tx(8'($urandom_range(0, 255)), -1);
  endtask

  task automatic test_loopback(input logic [7:0] d);
    logic [9:0] f;
    int v0, lat;
    bit seen;
    f = frame_of(d, 1'b1);
    v0 = valid_cnt;
    seen = 1'b0;
    lat = -1;
    loopback = 1'b1;
    if (RX_EN) exp_q.push_back(d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clock);
      if (n <= 10 * CPB) begin
        checks++;
        if (ser_tx !== f[(n - 1) / CPB] || tx_busy !== 1'b1) begin
          errors++;
          $display("FAIL loop_tx n=%0d got ser_tx=%b busy=%b exp ser_tx=%b busy=1",
                   n, ser_tx, tx_busy, f[(n - 1) / CPB]);
        end
      end
      if (rx_valid && !seen) begin
        seen = 1'b1;
        lat  = n - 2;  // measured from the ser_tx falling edge
      end
    end
    checks++;
    if (seen !== RX_EN) begin
      errors++;
      $display("FAIL loop_seen got=%b exp=%b", seen, RX_EN);
    end
    if (seen) begin
      checks++;
      if (lat < 153 || lat > 155) begin
        errors++;
        $display("FAIL loop_latency got=%0d exp=153..155", lat);
      end
    end
    checks++;
    if (valid_cnt - v0 !== (RX_EN ? 1 : 0) || rx_data !== (RX_EN ? d : 8'h00)) begin
      errors++;
      $display("FAIL loop_count got pulses=%0d data=%h exp pulses=%0d data=%h",
               valid_cnt - v0, rx_data, RX_EN ? 1 : 0, RX_EN ? d : 8'h00);
    end
    tx_start = 1'b0;
    repeat (3) @(negedge clock);
    loopback = 1'b0;
  endtask

  task automatic test_reset_mid;
    int v0, e0;
    loopback = 1'b1;
    @(negedge clock);
    tx_data  = 8'($urandom_range(0, 255));
    tx_start = 1'b1;
    repeat (50) @(negedge clock);
    v0 = valid_cnt;
    e0 = ferr_cnt;
    #2;
    reset    = 1'b1;
    tx_start = 1'b0;
    #1;
    checks++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || tx_clear_req !== 1'b0 ||
        rx_data !== 8'h00 || rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got tx=%b busy=%b clr=%b data=%h v=%b fe=%b",
               ser_tx, tx_busy, tx_clear_req, rx_data, rx_valid, rx_frame_err);
    end
    repeat (3) @(negedge clock);
    reset    = 1'b0;
    loopback = 1'b0;
    repeat (12 * CPB) @(negedge clock);
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== e0 || ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got v=%0d fe=%0d tx=%b busy=%b exp v=%0d fe=%0d tx=1 busy=0",
               valid_cnt, ferr_cnt, ser_tx, tx_busy, v0, e0);
    end
  endtask

  task automatic test_false_start;
    int v0, e0;
    logic [7:0] d;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    @(negedge clock);
    rx_line = 1'b0;
    repeat (4) @(negedge clock);
    rx_line = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    checks++;
    if (valid_cnt !== v0 || ferr_cnt !== e0) begin
      errors++;
      $display("FAIL false_start got v=%0d fe=%0d exp v=%0d fe=%0d", valid_cnt, ferr_cnt, v0, e0);
    end
    d = 8'($urandom_range(0, 255));
    if (RX_EN) exp_q.push_back(d);
    send_rx_frame(d, 1'b1);
    repeat (CPB) @(negedge clock);
    checks++;
    if (valid_cnt !== v0 + (RX_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL after_false_start got v=%0d exp=%0d", valid_cnt, v0 + (RX_EN ? 1 : 0));
    end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt;
    e0 = ferr_cnt;
    send_rx_frame(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clock);  // line held low: break
    checks++;
    if (ferr_cnt !== e0 + (RX_EN ? 1 : 0) || valid_cnt !== v0 ||
        rx_data !== (RX_EN ? 8'h55 : 8'h00)) begin
      errors++;
      $display("FAIL frame_err got fe=%0d v=%0d data=%h exp fe=%0d v=%0d data=%h",
               ferr_cnt, valid_cnt, rx_data, e0 + (RX_EN ? 1 : 0), v0, RX_EN ? 8'h55 : 8'h00);
    end
    rx_line = 1'b1;
    repeat (CPB) @(negedge clock);
    if (RX_EN) exp_q.push_back(8'h00);
    send_rx_frame(8'h00, 1'b1);
    repeat (CPB) @(negedge clock);
    checks++;
    if (valid_cnt !== v0 + (RX_EN ? 1 : 0) || ferr_cnt !== e0 + (RX_EN ? 1 : 0)) begin
      errors++;
      $display("FAIL after_break got v=%0d fe=%0d exp v=%0d fe=%0d",
               valid_cnt, ferr_cnt, v0 + (RX_EN ? 1 : 0), e0 + (RX_EN ? 1 : 0));
    end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      if (RX_EN) exp_q.push_back(d);
      send_rx_frame(d, 1'b1);
    end
    repeat (2 * CPB) @(negedge clock);
    checks++;
    if (valid_cnt !== v0 + (RX_EN ? 6 : 0)) begin
      errors++;
      $display("FAIL back_to_back got v=%0d exp=%0d", valid_cnt, v0 + (RX_EN ? 6 : 0));
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset;
    test_tx_held;
    test_tx_pulse;
    test_loopback(8'h3C);
    test_loopback(8'hFF);
    test_loopback(8'($urandom_range(0, 255)));
    test_reset_mid;
    test_false_start;
    test_frame_err;
    test_back_to_back;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
